// File: rtl/md_pkg.sv
// md_pkg: shared types and decode helpers for the iterative RV32M multiply/divide unit.
//   md_op_e     - operation codes, encoded exactly as the RV32M funct3 field
//   md_state_e  - sequencer states of mul_div_unit
//   is_div / is_rem / is_signed_a / is_signed_b - operation decode helpers
package md_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Divide-class ops all have funct3[2] set.
    function automatic logic is_div(md_op_e op);
        logic [2:0] code;
        code = op;
        return code[2];
    endfunction

    function automatic logic is_rem(md_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_a(md_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(md_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: combinational sign handling for mul_div_unit.
//   src_a, src_b     in   raw operands
//   signed_a/b       in   operand is interpreted as two's complement
//   sign_a, sign_b   out  operand is negative under its interpretation
//   mag_a, mag_b     out  operand magnitudes (|MIN_NEG| comes out as an unsigned value)
//   raw_res          in   double-width unsigned result from the iterative datapath
//   neg_res          in   negate the result
//   fixed_res        out  raw_res, negated modulo 2^(2*DATA_WIDTH) when neg_res
module md_sign_fix #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    input  logic                    signed_a,
    input  logic                    signed_b,
    output logic                    sign_a,
    output logic                    sign_b,
    output logic [DATA_WIDTH-1:0]   mag_a,
    output logic [DATA_WIDTH-1:0]   mag_b,
    input  logic [2*DATA_WIDTH-1:0] raw_res,
    input  logic                    neg_res,
    output logic [2*DATA_WIDTH-1:0] fixed_res
);

    always_comb begin
        sign_a    = signed_a & src_a[DATA_WIDTH-1];
        sign_b    = signed_b & src_b[DATA_WIDTH-1];
        mag_a     = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b     = sign_b ? (~src_b + 1'b1) : src_b;
        // Negating the full double width keeps the high half of a product correct.
        fixed_res = neg_res ? (~raw_res + 1'b1) : raw_res;
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one result bit per cycle.
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   Valid_i      in   operation request
//   Ready_o      out  idle; a request is accepted this cycle when Valid_i is high
//   MDControl_i  in   funct3 operation code (see md_pkg::md_op_e)
//   SrcA_i       in   rs1 operand
//   SrcB_i       in   rs2 operand
//   Flush_i      in   abort the in-flight operation (overrides Valid_i)
//   Valid_o      out  one-cycle pulse, Result_o valid
//   Result_o     out  registered result, held until the next completion
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic [2:0]            MDControl_i,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic                  Flush_i,
    output logic                  Valid_o,
    output logic [DATA_WIDTH-1:0] Result_o
);

    import md_pkg::*;

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    md_state_e               state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    md_op_e                  op_q, op_d;
    logic                    neg_q, neg_d;
    logic [DATA_WIDTH-1:0]   mag_b_q, mag_b_d;
    // Multiply accumulator: high half sums partial products, low half shifts out the multiplier.
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH:0]     rem_q, rem_d;
    // Quotient register starts as the dividend and shifts quotient bits in from the bottom.
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    md_op_e                  op_in;
    logic                    sign_a, sign_b;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    div_zero, div_ovf;
    logic [DATA_WIDTH-1:0]   special_res;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] acc_nxt;
    logic [DATA_WIDTH+1:0]   rem_shift, rem_trial;
    logic                    div_ok;
    logic [DATA_WIDTH:0]     rem_nxt;
    logic [DATA_WIDTH-1:0]   quo_nxt;
    logic [2*DATA_WIDTH-1:0] raw_res, fixed_res;
    logic [DATA_WIDTH-1:0]   calc_res;

    assign op_in = md_op_e'(MDControl_i);

    md_sign_fix #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sign_fix (
        .src_a     (SrcA_i),
        .src_b     (SrcB_i),
        .signed_a  (is_signed_a(op_in)),
        .signed_b  (is_signed_b(op_in)),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .raw_res   (raw_res),
        .neg_res   (neg_q),
        .fixed_res (fixed_res)
    );

    // Cases resolved at acceptance without iterating.
    always_comb begin
        div_zero    = is_div(op_in) && (SrcB_i == '0);
        div_ovf     = ((op_in == DIV) || (op_in == REM)) && (SrcA_i == MinNeg) && (SrcB_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem(op_in) ? SrcA_i : '1;
        end else if (div_ovf) begin
            special_res = is_rem(op_in) ? '0 : MinNeg;
        end
    end

    // One iteration of the shift-add multiplier and the restoring divider.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        acc_nxt   = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_trial = rem_shift - {2'b00, mag_b_q};
        div_ok    = ~rem_trial[DATA_WIDTH+1];
        rem_nxt   = div_ok ? rem_trial[DATA_WIDTH:0] : rem_shift[DATA_WIDTH:0];
        quo_nxt   = {quo_q[DATA_WIDTH-2:0], div_ok};
    end

    // Final-iteration result, sign corrected and selected by op.
    always_comb begin
        if (is_div(op_q)) begin
            raw_res = {{DATA_WIDTH{1'b0}}, (is_rem(op_q) ? rem_nxt[DATA_WIDTH-1:0] : quo_nxt)};
        end else begin
            raw_res = acc_nxt;
        end
        if ((op_q == MUL) || is_div(op_q)) begin
            calc_res = fixed_res[DATA_WIDTH-1:0];
        end else begin
            calc_res = fixed_res[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (Valid_i && !Flush_i) begin
                    op_d    = op_in;
                    // Remainder follows the dividend; product and quotient follow sign_a ^ sign_b.
                    neg_d   = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
                    mag_b_d = mag_b;
                    acc_d   = {{DATA_WIDTH{1'b0}}, mag_a};
                    rem_d   = '0;
                    quo_d   = mag_a;
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_nxt;
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    result_d = calc_res;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything: no completion, result untouched.
        if (Flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign Ready_o  = (state_q == IDLE);
    assign Valid_o  = (state_q == DONE);
    assign Result_o = result_q;

endmodule
